// File: rtl/a23_copro_cfg_seq.sv
// rtl/a23_copro_cfg_seq.sv - CP15 co-processor bus configuration initiator (MCR writes, optional flush).
// Define A23_COPRO_CFG_VERIFY_EN to add MRC read-back and compare of crn2..5 after the writes.
module a23_copro_cfg_seq #(
    parameter logic [3:0]  COPRO_NUM     = 4'd15,
    parameter bit          FLUSH_EN      = 1'b1,
    parameter logic [15:0] STALL_TIMEOUT = 16'd0
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_fetch_stall,
    input  logic        i_start,
    input  logic [2:0]  i_cfg_control,
    input  logic [31:0] i_cfg_cacheable,
    input  logic [31:0] i_cfg_updateable,
    input  logic [31:0] i_cfg_disruptive,
    input  logic [31:0] i_copro_read_data,
    output logic [1:0]  o_copro_operation,
    output logic [3:0]  o_copro_crn,
    output logic [3:0]  o_copro_crm,
    output logic [2:0]  o_copro_opcode1,
    output logic [2:0]  o_copro_opcode2,
    output logic [3:0]  o_copro_num,
    output logic [31:0] o_copro_write_data,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_error,
    output logic [3:0]  o_err_crn
);
    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_FLUSH, S_DONE
`ifdef A23_COPRO_CFG_VERIFY_EN
        , S_RD, S_CHK
`endif
    } state_t;

`ifdef A23_COPRO_CFG_VERIFY_EN
    localparam state_t S_POST_WR = S_RD;
`else
    localparam state_t S_POST_WR = S_DONE;
    logic unused_rdata;
    assign unused_rdata = ^i_copro_read_data;
`endif

    state_t      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [3:0]  crn_q, crn_d;
    logic [31:0] wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        error_q, error_d;
    logic [3:0]  err_crn_q, err_crn_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [2:0]  ctl_q;
    logic [31:0] cacheable_q, updateable_q, disruptive_q;
    logic        latch_cfg;

    logic [15:0] stall_cnt_inc;
    logic        timeout_hit;
    logic [3:0]  crn_nxt;
    logic [31:0] exp_nxt;

    assign stall_cnt_inc = (stall_cnt_q == 16'hffff) ? stall_cnt_q : stall_cnt_q + 16'd1;
    assign timeout_hit   = (STALL_TIMEOUT != 16'd0) && (op_q != 2'd0) && i_fetch_stall
                           && (stall_cnt_inc >= STALL_TIMEOUT);
    assign crn_nxt       = crn_q + 4'd1;

    always_comb begin
        case (crn_nxt)
            4'd2:    exp_nxt = {29'd0, ctl_q};
            4'd3:    exp_nxt = cacheable_q;
            4'd4:    exp_nxt = updateable_q;
            default: exp_nxt = disruptive_q;
        endcase
    end

`ifdef A23_COPRO_CFG_VERIFY_EN
    logic [31:0] exp_cur;
    always_comb begin
        case (crn_q)
            4'd2:    exp_cur = {29'd0, ctl_q};
            4'd3:    exp_cur = cacheable_q;
            4'd4:    exp_cur = updateable_q;
            default: exp_cur = disruptive_q;
        endcase
    end
`endif

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        crn_d       = crn_q;
        wdata_d     = wdata_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        error_d     = error_q;
        err_crn_d   = err_crn_q;
        latch_cfg   = 1'b0;
        stall_cnt_d = ((op_q != 2'd0) && i_fetch_stall) ? stall_cnt_inc : 16'd0;
        case (state_q)
            S_IDLE: if (i_start) begin
                latch_cfg = 1'b1;
                error_d   = 1'b0;
                err_crn_d = 4'd0;
                busy_d    = 1'b1;
                state_d   = S_WR;
                op_d      = 2'd2;
                crn_d     = 4'd2;
                wdata_d   = {29'd0, i_cfg_control};
            end
            S_WR: if (!i_fetch_stall) begin
                if (crn_q != 4'd5) begin
                    crn_d   = crn_nxt;
                    wdata_d = exp_nxt;
                end else if (FLUSH_EN) begin
                    state_d = S_FLUSH;
                    crn_d   = 4'd1;
                    wdata_d = 32'd0;
                end else begin
                    state_d = S_POST_WR;
                    op_d    = 2'd1;
                    crn_d   = 4'd2;
                    wdata_d = 32'd0;
                end
            end
            S_FLUSH: if (!i_fetch_stall) begin
                state_d = S_POST_WR;
                op_d    = 2'd1;
                crn_d   = 4'd2;
                wdata_d = 32'd0;
            end
`ifdef A23_COPRO_CFG_VERIFY_EN
            S_RD: if (!i_fetch_stall) begin
                state_d = S_CHK;
                op_d    = 2'd0;
            end
            // Read data is compared on the advancing edge; only the first failure is recorded.
            S_CHK: if (!i_fetch_stall) begin
                if ((i_copro_read_data != exp_cur) && !error_q) begin
                    error_d   = 1'b1;
                    err_crn_d = crn_q;
                end
                if (crn_q != 4'd5) begin
                    state_d = S_RD;
                    op_d    = 2'd1;
                    crn_d   = crn_nxt;
                end else begin
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (timeout_hit) begin
            state_d = S_DONE;
            error_d = 1'b1;
            if (!error_q) err_crn_d = 4'hf;
        end
        // Entering DONE releases the bus and pulses done for a single cycle.
        if ((state_d == S_DONE) && (state_q != S_DONE)) begin
            op_d    = 2'd0;
            crn_d   = 4'd0;
            wdata_d = 32'd0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            op_q         <= 2'd0;
            crn_q        <= 4'd0;
            wdata_q      <= 32'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            err_crn_q    <= 4'd0;
            stall_cnt_q  <= 16'd0;
            ctl_q        <= 3'd0;
            cacheable_q  <= 32'd0;
            updateable_q <= 32'd0;
            disruptive_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            crn_q       <= crn_d;
            wdata_q     <= wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_crn_q   <= err_crn_d;
            stall_cnt_q <= stall_cnt_d;
            if (latch_cfg) begin
                ctl_q        <= i_cfg_control;
                cacheable_q  <= i_cfg_cacheable;
                updateable_q <= i_cfg_updateable;
                disruptive_q <= i_cfg_disruptive;
            end
        end
    end

    assign o_copro_operation  = op_q;
    assign o_copro_crn        = crn_q;
    assign o_copro_crm        = 4'd0;
    assign o_copro_opcode1    = 3'd0;
    assign o_copro_opcode2    = 3'd0;
    assign o_copro_num        = COPRO_NUM;
    assign o_copro_write_data = wdata_q;
    assign o_busy             = busy_q;
    assign o_done             = done_q;
    assign o_error            = error_q;
    assign o_err_crn          = err_crn_q;
endmodule

// File: tb/tb_a23_copro_cfg_seq.sv
// tb/tb_a23_copro_cfg_seq.sv - self-checking bench for a23_copro_cfg_seq (vector table, random stalls, CP15 responder model).
module tb_a23_copro_cfg_seq;
`ifdef A23_COPRO_CFG_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif
    localparam int VX = VERIFY ? 8 : 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall_a = 1'b0, stall_b = 1'b0, start = 1'b0;
    logic [2:0]  ctl = 3'd0;
    logic [31:0] cach = 32'd0, upd = 32'd0, dis = 32'd0;
    logic [31:0] rdata_a = 32'd0;
    logic [31:0] rdata_b = 32'd0;

    logic [1:0]  op_a, op_b;
    logic [3:0]  crn_a, crn_b, crm_a, crm_b, num_a, num_b, ecrn_a, ecrn_b;
    logic [2:0]  opc1_a, opc1_b, opc2_a, opc2_b;
    logic [31:0] wd_a, wd_b;
    logic        busy_a, busy_b, done_a, done_b, err_a, err_b;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    a23_copro_cfg_seq dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_fetch_stall(stall_a), .i_start(start),
        .i_cfg_control(ctl), .i_cfg_cacheable(cach), .i_cfg_updateable(upd), .i_cfg_disruptive(dis),
        .i_copro_read_data(rdata_a), .o_copro_operation(op_a), .o_copro_crn(crn_a), .o_copro_crm(crm_a),
        .o_copro_opcode1(opc1_a), .o_copro_opcode2(opc2_a), .o_copro_num(num_a), .o_copro_write_data(wd_a),
        .o_busy(busy_a), .o_done(done_a), .o_error(err_a), .o_err_crn(ecrn_a)
    );

    a23_copro_cfg_seq #(.COPRO_NUM(4'd15), .FLUSH_EN(1'b0), .STALL_TIMEOUT(16'd4)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_fetch_stall(stall_b), .i_start(start),
        .i_cfg_control(ctl), .i_cfg_cacheable(cach), .i_cfg_updateable(upd), .i_cfg_disruptive(dis),
        .i_copro_read_data(rdata_b), .o_copro_operation(op_b), .o_copro_crn(crn_b), .o_copro_crm(crm_b),
        .o_copro_opcode1(opc1_b), .o_copro_opcode2(opc2_b), .o_copro_num(num_b), .o_copro_write_data(wd_b),
        .o_busy(busy_b), .o_done(done_b), .o_error(err_b), .o_err_crn(ecrn_b)
    );

    // CP15 responder: stores accepted MCR data, returns it one edge after an accepted MRC.
    logic [31:0] regs [0:15];
    bit corrupt4 = 1'b0;
    always @(posedge clk) begin
        if (rst_n && (op_a != 2'd0) && !stall_a) begin
            if (op_a == 2'd2) regs[crn_a] <= wd_a;
            else rdata_a <= (corrupt4 && crn_a == 4'd4) ? 32'h0 : regs[crn_a];
        end
    end

    typedef struct {
        logic [2:0]  ctl;
        logic [31:0] c, u, d;
        int          st, len, rep, done;
        bit          corrupt;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic run_seq(input vec_t v, input bit rnd, input int exp_done);
        logic [1:0]  qop[$];
        logic [3:0]  qcrn[$];
        logic [31:0] qdat[$];
        logic [1:0]  pop;
        logic [3:0]  pcrn;
        logic [31:0] pdat;
        int cyc, nfree, slots;
        bit seen, st, pst;
        for (int n = 2; n <= 5; n++) begin
            qop.push_back(2'd2);
            qcrn.push_back(4'(n));
            qdat.push_back(n == 2 ? {29'd0, v.ctl} : n == 3 ? v.c : n == 4 ? v.u : v.d);
        end
        qop.push_back(2'd2); qcrn.push_back(4'd1); qdat.push_back(32'd0);
        if (VERIFY) for (int n = 2; n <= 5; n++) begin
            qop.push_back(2'd1); qcrn.push_back(4'(n)); qdat.push_back(32'd0);
        end
        slots = 5 + VX;
        corrupt4 = v.corrupt;
        @(negedge clk);
        ctl = v.ctl; cach = v.c; upd = v.u; dis = v.d; start = 1'b1; stall_a = 1'b0;
        @(negedge clk);
        start = 1'b0; cyc = 1; nfree = 0; pst = 1'b0; seen = 1'b0;
        pop = 2'd0; pcrn = 4'd0; pdat = 32'd0;
        while (!seen && cyc < 200) begin
            if (done_a) begin
                seen = 1'b1;
                if (exp_done > 0) chk("done_cycle", cyc, exp_done);
                chk("free_cycles", nfree, slots);
                chk("ops_left", qop.size(), 0);
                chk("busy_at_done", busy_a, 1'b0);
                chk("op_at_done", op_a, 2'd0);
                chk("error", err_a, v.corrupt && VERIFY);
                chk("err_crn", ecrn_a, (v.corrupt && VERIFY) ? 4'd4 : 4'd0);
            end else begin
                chk("busy", busy_a, 1'b1);
                if (pst && pop != 2'd0) begin
                    chk("hold_op", op_a, pop);
                    chk("hold_crn", crn_a, pcrn);
                    chk("hold_data", wd_a, pdat);
                end
                st = rnd ? ($urandom_range(0, 9) < 3) : (cyc >= v.st && cyc < v.st + v.len);
                stall_a = st;
                if (cyc == v.rep) begin
                    start = 1'b1; ctl = ~v.ctl; cach = ~v.c; upd = ~v.u; dis = ~v.d;
                end else begin
                    start = 1'b0;
                end
                if (!st) begin
                    nfree++;
                    if (op_a != 2'd0) begin
                        if (qop.size() == 0) chk("extra_op", op_a, 2'd0);
                        else begin
                            chk("acc_op", op_a, qop.pop_front());
                            chk("acc_crn", crn_a, qcrn.pop_front());
                            chk("acc_data", wd_a, qdat.pop_front());
                        end
                    end
                end
                pop = op_a; pcrn = crn_a; pdat = wd_a; pst = st;
                @(negedge clk);
                cyc++;
            end
        end
        if (!seen) chk("done_timeout", 32'd0, 32'd1);
        stall_a = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("done_pulse_width", done_a, 1'b0);
        chk("idle_busy", busy_a, 1'b0);
        repeat (12) @(negedge clk);
    endtask

    task automatic run_b(input bit hold, input int exp_done, input logic exp_err, input logic [3:0] exp_crn);
        int cyc;
        bit seen;
        @(negedge clk);
        ctl = 3'd0; cach = 32'd0; upd = 32'd0; dis = 32'd0; corrupt4 = 1'b0;
        start = 1'b1; stall_b = hold; stall_a = 1'b0;
        @(negedge clk);
        start = 1'b0; cyc = 1; seen = 1'b0;
        while (!seen && cyc < 60) begin
            if (done_b) begin
                seen = 1'b1;
                chk("b_done_cycle", cyc, exp_done);
                chk("b_error", err_b, exp_err);
                chk("b_err_crn", ecrn_b, exp_crn);
                chk("b_op_at_done", op_b, 2'd0);
            end else begin
                if (hold) begin
                    chk("b_stall_op", op_b, 2'd2);
                    chk("b_stall_crn", crn_b, 4'd2);
                end
                @(negedge clk);
                cyc++;
            end
        end
        if (!seen) chk("b_done_timeout", 32'd0, 32'd1);
        stall_b = 1'b0;
        repeat (20) @(negedge clk);
    endtask

    vec_t vt[5];

    initial begin
        vt[0] = '{3'b101, 32'h1, 32'h3, 32'h7, 0, 0, 0, 6, 1'b0};
        vt[1] = '{3'b010, 32'hdead_beef, 32'h1234_5678, 32'hffff_ffff, 2, 3, 0, 9, 1'b0};
        vt[2] = '{3'b111, 32'h8000_0000, 32'h0000_00f0, 32'h5, 0, 0, 0, 6, 1'b1};
        vt[3] = '{3'b011, 32'haaaa_5555, 32'h0f0f_0f0f, 32'h1111_2222, 0, 0, 2, 6, 1'b0};
        vt[4] = '{3'b001, 32'h0000_ffff, 32'hffff_0000, 32'h0, 5, 2, 0, 8, 1'b0};

        repeat (2) @(negedge clk);
        chk("rst_op", op_a, 2'd0);
        chk("rst_crn", crn_a, 4'd0);
        chk("rst_data", wd_a, 32'd0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_done", done_a, 1'b0);
        chk("rst_error", err_a, 1'b0);
        chk("rst_err_crn", ecrn_a, 4'd0);
        chk("num", num_a, 4'd15);
        chk("crm", crm_a, 4'd0);
        chk("opc1", opc1_a, 3'd0);
        chk("opc2", opc2_a, 3'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) run_seq(vt[i], 1'b0, vt[i].done + VX);

        run_b(1'b0, 5 + VX, 1'b0, 4'd0);
        run_b(1'b1, 5, 1'b1, 4'hf);

        // Reset during the crn4 write (cycle 3) must clear outputs immediately.
        @(negedge clk);
        ctl = 3'b110; cach = 32'h11; upd = 32'h22; dis = 32'h33; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_crn", crn_a, 4'd4);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_op", op_a, 2'd0);
        chk("arst_crn", crn_a, 4'd0);
        chk("arst_data", wd_a, 32'd0);
        chk("arst_busy", busy_a, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_op", op_a, 2'd0);
            chk("post_rst_busy", busy_a, 1'b0);
        end
        run_seq(vt[0], 1'b0, vt[0].done + VX);

        for (int i = 0; i < 15; i++) begin
            vec_t r;
            r.ctl = 3'($urandom);
            r.c = $urandom; r.u = $urandom; r.d = $urandom;
            r.st = 0; r.len = 0; r.rep = 0; r.done = 0; r.corrupt = 1'b0;
            run_seq(r, 1'b1, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
